// File: rtl/spi_regs_master.sv
// Round-robin SPI master sharing one register slave between NUM_REQ requesters.
// Define SPI_FIXED_PRIO_EN for fixed lowest-index-wins arbitration instead.
module spi_regs_master #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 2,
    parameter int CLK_DIV = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_rd,
    input  logic [NUM_REQ*5-1:0]     req_addr,
    input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]       done,
    output logic [WIDTH-1:0]         rdata,
    output logic                     rdata_valid,
    output logic                     busy,
    output logic                     spi_sck,
    output logic                     spi_cs,
    output logic                     spi_si,
    input  logic                     spi_so
);
    localparam int TOT = 8 + WIDTH;
    localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW  = $clog2(CLK_DIV);
    localparam int BW  = $clog2(TOT + 1);

    typedef enum logic [2:0] {S_IDLE, S_GRANT, S_SHIFT, S_FLUSH, S_DONE} state_t;

    state_t             state_q;
    logic [IW-1:0]      win_q;
    logic               rd_q;
    logic [TOT-2:0]     shift_q;   // word minus its constant-zero MSB
    logic [WIDTH-1:0]   rsh_q;
    logic [PW-1:0]      ph_q;
    logic [BW-1:0]      bit_q;
    logic               sck_q, cs_q, si_q, rv_q, busy_q;
    logic [NUM_REQ-1:0] done_q;
    logic [WIDTH-1:0]   rdata_q;
`ifndef SPI_FIXED_PRIO_EN
    logic [IW-1:0]      rr_q;
`endif

    logic [IW-1:0]      win_d;
    logic               any_d;
    logic               rd_sel_s;
    logic [4:0]         addr_sel_s;
    logic [WIDTH-1:0]   wdata_sel_s;

    // Arbitration: choose the next requester to serve.
    always_comb begin
        win_d = '0;
        any_d = 1'b0;
`ifdef SPI_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            win_d = req[i] ? IW'(i) : win_d;
            any_d = any_d | req[i];
        end
`else
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx   = int'(rr_q) + k;
            idx   = (idx >= NUM_REQ) ? idx - NUM_REQ : idx;
            win_d = (!any_d && req[IW'(idx)]) ? IW'(idx) : win_d;
            any_d = any_d | req[IW'(idx)];
        end
`endif
    end

    // Select the granted requester's fields for latching into the shadow word.
    always_comb begin
        rd_sel_s    = 1'b0;
        addr_sel_s  = 5'd0;
        wdata_sel_s = {WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            rd_sel_s    = (win_q == IW'(i)) ? req_rd[i] : rd_sel_s;
            addr_sel_s  = (win_q == IW'(i)) ? req_addr[i*5 +: 5] : addr_sel_s;
            wdata_sel_s = (win_q == IW'(i)) ? req_wdata[i*WIDTH +: WIDTH] : wdata_sel_s;
        end
    end

    // Transaction FSM with registered SPI pins and handshake outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            rd_q    <= 1'b0;
            shift_q <= '0;
            rsh_q   <= '0;
            ph_q    <= '0;
            bit_q   <= '0;
            sck_q   <= 1'b0;
            cs_q    <= 1'b0;
            si_q    <= 1'b0;
            rv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= '0;
            rdata_q <= '0;
`ifndef SPI_FIXED_PRIO_EN
            rr_q    <= IW'(NUM_REQ - 1);
`endif
        end else begin
            done_q <= '0;
            rv_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (any_d) begin
                        win_q   <= win_d;
                        busy_q  <= 1'b1;
                        state_q <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    rd_q    <= rd_sel_s;
                    shift_q <= {1'b0, rd_sel_s, addr_sel_s,
                                rd_sel_s ? {WIDTH{1'b0}} : wdata_sel_s};
                    rsh_q   <= '0;
                    cs_q    <= 1'b1;
                    si_q    <= 1'b0;
                    sck_q   <= 1'b0;
                    ph_q    <= '0;
                    bit_q   <= '0;
                    state_q <= S_SHIFT;
`ifndef SPI_FIXED_PRIO_EN
                    rr_q    <= win_q;
`endif
                end
                S_SHIFT: begin
                    if (ph_q == PW'(CLK_DIV - 1)) begin
                        ph_q <= '0;
                        if (!sck_q) begin
                            sck_q <= 1'b1;
                            if (rd_q && bit_q >= BW'(8)) begin
                                rsh_q <= {rsh_q[WIDTH-2:0], spi_so};
                            end
                        end else begin
                            sck_q <= 1'b0;
                            if (bit_q == BW'(TOT - 1)) begin
                                cs_q    <= 1'b0;
                                si_q    <= 1'b0;
                                bit_q   <= '0;
                                state_q <= S_FLUSH;
                            end else begin
                                bit_q   <= bit_q + 1'b1;
                                si_q    <= shift_q[TOT-2];
                                shift_q <= {shift_q[TOT-3:0], 1'b0};
                            end
                        end
                    end else begin
                        ph_q <= ph_q + 1'b1;
                    end
                end
                S_FLUSH: begin
                    // bit_q counts the low/high/low half-periods of the trailing pulse
                    if (ph_q == PW'(CLK_DIV - 1)) begin
                        ph_q <= '0;
                        if (bit_q == BW'(2)) begin
                            done_q[win_q] <= 1'b1;
                            rv_q          <= rd_q;
                            if (rd_q) begin
                                rdata_q <= rsh_q;
                            end
                            bit_q   <= '0;
                            state_q <= S_DONE;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            sck_q <= ~sck_q;
                        end
                    end else begin
                        ph_q <= ph_q + 1'b1;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    ph_q    <= '0;
                    bit_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    cs_q    <= 1'b0;
                    sck_q   <= 1'b0;
                    si_q    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign done        = done_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rv_q;
    assign busy        = busy_q;
    assign spi_sck     = sck_q;
    assign spi_cs      = cs_q;
    assign spi_si      = si_q;
endmodule

// File: doc/spi_regs_master.md
Name: spi_regs_master

Overview:
- Round-robin SPI master that shares the Ozy GPIO/SPI register slave between NUM_REQ on-board requesters.
- Each requester posts a register read or write. The block arbitrates and serialises the 8-bit address byte plus a WIDTH-bit data phase onto spi_sck/spi_cs/spi_si, then captures spi_so on reads.
- After each transfer it generates the trailing SCK pulse the slave needs to clear its write strobe.
- Sits in the IFCLK domain between the command decoders and the slave's SCK/CS/SI/SO pins.

Parameters:
- WIDTH, 8, data bits per register.
- NUM_REQ, 2, number of requesters (1..8).
- CLK_DIV, 4, clock cycles per SCK half-period (>=2).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  request level per requester; held until its done pulse.
- req_rd  in  NUM_REQ  1 = read, 0 = write.
- req_addr  in  NUM_REQ*5  register address, slice i = [5i+4:5i].
- req_wdata  in  NUM_REQ*WIDTH  write data, slice i.
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- rdata  out  WIDTH  captured read data; holds until next read completes.
- rdata_valid  out  1  one-cycle pulse coincident with done on reads.
- busy  out  1  high from grant through done.
- spi_sck  out  1  serial clock, idle low.
- spi_cs  out  1  chip select, active high.
- spi_si  out  1  serial data to slave, MSB first.
- spi_so  in  1  serial data from slave.

Behaviour:
- Reset values (async, reset_n low): spi_sck=0, spi_cs=0, spi_si=0, done=0, rdata=0, rdata_valid=0, busy=0, state=IDLE, rr pointer=NUM_REQ-1. Reset mid-transfer aborts immediately; no done pulse is issued.
- States: IDLE -> GRANT -> SHIFT -> FLUSH -> DONE -> IDLE.
- IDLE: if any req bit is set, pick the first set bit strictly after the rr pointer (wrapping), then go to GRANT. Otherwise stay in IDLE.
- GRANT (1 cycle):
  - latch the winner index, rd, addr and wdata into a shadow register;
  - build shift word {2'b00, rd, addr[4:0], wdata}; on reads the data field is 0;
  - set busy=1 and update the rr pointer to the winner.
- SHIFT:
  - spi_cs=1 from the first SHIFT cycle.
  - Each of the 8+WIDTH bits: spi_si drives the current MSB with SCK low for CLK_DIV clocks, then SCK is high for CLK_DIV clocks.
  - The shift word advances on the SCK falling transition.
  - On reads, spi_so is sampled on the clock that raises SCK for bit indices 8..8+WIDTH-1, and shifted into rdata_shift MSB first.
- FLUSH:
  - spi_cs=0 and spi_si=0.
  - SCK low CLK_DIV, high CLK_DIV, low CLK_DIV. This one pulse with CS low clears the slave's strobe and read state.
- DONE (1 cycle): done[winner]=1. On reads, rdata<=rdata_shift and rdata_valid=1. busy drops on entry to IDLE.
- Timing: done asserts exactly (2*(8+WIDTH)+3)*CLK_DIV clocks after spi_cs rises, which is 140 clocks for the defaults. Back-to-back grants have a minimum 2-cycle gap (DONE, IDLE) between done and the next spi_cs rise.
- A requester dropping req before GRANT is simply not granted. Changes to req or fields after GRANT are ignored, because the shadow register is used.
- Simultaneous requests are served one per transaction in round-robin order. No requester waits more than NUM_REQ-1 transactions.
- SCK phase and bit counters are sized as ceil(log2(CLK_DIV)) and ceil(log2(8+WIDTH+1)). Counters reset on each state entry.

Optional Feature:
- Macro SPI_FIXED_PRIO_EN.
- Defined: arbitration is fixed priority, lowest index wins; the rr pointer is removed.
- Undefined: round-robin as described above.
- All timing is identical in both builds.

Test Plan:
- Write, req[0], addr=5'h03, wdata=8'hA5, CLK_DIV=4:
  - SI bit stream is 00_0_00011_10100101 across 16 SCK rising edges with CS high;
  - then one SCK pulse with CS low;
  - done[0] pulses 140 clocks after CS rise; rdata_valid=0.
- Read, req[1], addr=5'h02, slave model returns 8'h3C on SO after edge 8:
  - address byte on SI is 8'b00100010;
  - rdata=8'h3C with rdata_valid and done[1] pulsing in the same cycle.
- req[0] and req[1] both held continuously for 4 transactions (rr reset state): grant order 0,1,0,1. With SPI_FIXED_PRIO_EN: 0,0,0,0.
- req_wdata[0] changed from 8'hA5 to 8'h00 one cycle after GRANT: transmitted data remains 8'hA5.
- reset_n asserted at SCK edge 6 of a write: spi_cs, spi_sck and spi_si are 0 immediately and no done pulse. After release with req[0] still high, a full clean transaction follows.
- req[1] pulsed for one cycle while busy with req[0], then dropped: req[1] is never granted and done[1] stays 0.
